// File: rtl/mem_bus_master.sv
// Initiator side of the CPU memory-mapped data bus: one load/store at a time, with
// waitrequest stalls, byte-lane packing, load extension and a stall timeout.
module mem_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] address,
    output logic [3:0]  byteenable,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdData,
        StWrReq,
        StResp
    } state_t;

    // Wide enough to hold TIMEOUT_CYCLES and still saturate above it.
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 2);

    state_t          r_state;
    logic [CntW-1:0] r_wait_cnt;
    logic [31:0]     r_address;
    logic [3:0]      r_byteenable;
    logic [31:0]     r_writedata;
    logic            r_read;
    logic            r_write;
    logic            r_resp_valid;
    logic            r_resp_error;
    logic [31:0]     r_resp_rdata;
    logic [1:0]      r_lane;
    logic [1:0]      r_size;
    logic            r_signed;

    logic            w_misaligned;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [7:0]      w_rd_byte;
    logic [15:0]     w_rd_half;
    logic [31:0]     w_load;
    logic            w_timeout;

    assign req_ready  = (r_state == StIdle);
    assign resp_valid = r_resp_valid;
    assign resp_error = r_resp_error;
    assign resp_rdata = r_resp_rdata;
    assign address    = r_address;
    assign byteenable = r_byteenable;
    assign read       = r_read;
    assign write      = r_write;
    assign writedata  = r_writedata;

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b0000;
        w_wdata      = 32'h0;
        case (req_size)
            2'd0: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_be         = 4'b0011 << req_addr[1:0];
                w_wdata      = {2{req_wdata[15:0]}};
                w_misaligned = req_addr[0];
            end
            2'd2: begin
                w_be         = 4'b1111;
                w_wdata      = req_wdata;
                w_misaligned = |req_addr[1:0];
            end
            default: w_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        w_rd_byte = readdata[7:0];
        case (r_lane)
            2'd0:    w_rd_byte = readdata[7:0];
            2'd1:    w_rd_byte = readdata[15:8];
            2'd2:    w_rd_byte = readdata[23:16];
            default: w_rd_byte = readdata[31:24];
        endcase
        w_rd_half = r_lane[1] ? readdata[31:16] : readdata[15:0];
        case (r_size)
            2'd0:    w_load = r_signed ? {{24{w_rd_byte[7]}}, w_rd_byte} : {24'h0, w_rd_byte};
            2'd1:    w_load = r_signed ? {{16{w_rd_half[15]}}, w_rd_half} : {16'h0, w_rd_half};
            default: w_load = readdata;
        endcase
    end

    // Abort on the stall edge that would bring the count up to TIMEOUT_CYCLES.
    assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                       ((32'(r_wait_cnt) + 32'd1) >= TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_wait_cnt   <= '0;
            r_address    <= 32'h0;
            r_byteenable <= 4'b0000;
            r_writedata  <= 32'h0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_lane       <= 2'd0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        if (w_misaligned) begin
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else begin
                            r_address    <= {req_addr[31:2], 2'b00};
                            r_byteenable <= w_be;
                            r_writedata  <= w_wdata;
                            r_lane       <= req_addr[1:0];
                            r_size       <= req_size;
                            r_signed     <= req_signed;
                            r_wait_cnt   <= '0;
                            if (req_write) begin
                                r_write <= 1'b1;
                                r_state <= StWrReq;
                            end else begin
                                r_read  <= 1'b1;
                                r_state <= StRdReq;
                            end
                        end
                    end
                end
                StRdReq, StWrReq: begin
                    if (!waitrequest) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_state == StRdReq) begin
                            r_state <= StRdData;
                        end else begin
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b0;
                        end
                    end else begin
                        if (r_wait_cnt != '1) begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                        if (w_timeout) begin
                            r_read       <= 1'b0;
                            r_write      <= 1'b0;
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end
                    end
                end
                StRdData: begin
                    r_resp_rdata <= w_load;
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b0;
                    r_state      <= StResp;
                end
                StResp:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
